rom_dump_sequencer: RTL and testbench

- Automatic controller for the ROM reader datapath.
- Resets the reader, then steps its address counter by pulsing increment_address, and waits for the chip data to settle.
- Captures each word and streams it out as (address, data) over a valid/ready handshake, feeding a host link such as a UART packer.
- Replaces the manual push-button stepping and checks that the reader's address tracks the expected index.

---
 rtl/rom_reader_pkg.sv | 34 +++
 rtl/rom_seq_timer.sv | 36 +++
 rtl/rom_dump_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_rom_dump_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_reader_pkg.sv
// Shared definitions for the ROM reader and its automatic dump sequencer.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    CHIP_556PT5 = 2'd0,
    CHIP_556PT4 = 2'd1
  } chip_id_e;

  localparam int unsigned PT5_DATA_WIDTH    = 8;
  localparam int unsigned PT5_ADDRESS_WIDTH = 9;
  localparam int unsigned PT4_DATA_WIDTH    = 4;
  localparam int unsigned PT4_ADDRESS_WIDTH = 8;

  localparam int unsigned DEFAULT_RESET_CYCLES  = 2;
  localparam int unsigned DEFAULT_PULSE_CYCLES  = 2;
  localparam int unsigned DEFAULT_GAP_CYCLES    = 3;
  localparam int unsigned DEFAULT_SETTLE_CYCLES = 4;
  localparam int unsigned TIMER_WIDTH           = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_RESET = 3'd1,
    SETTLE   = 3'd2,
    PRESENT  = 3'd3,
    PULSE_HI = 3'd4,
    PULSE_LO = 3'd5,
    DONE     = 3'd6
  } seq_state_e;

  function automatic logic is_busy(input seq_state_e s);
    return !((s == IDLE) || (s == DONE));
  endfunction

endpackage

// File: rtl/rom_seq_timer.sv
// Loadable down-counter; expired_c is high while the count sits at zero.
module rom_seq_timer
  import rom_reader_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired_c
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_c = (count_q == '0);

endmodule

// File: rtl/rom_dump_sequencer.sv
// Steps the ROM reader through WORD_COUNT addresses and streams each
// (address, data) pair out over valid/ready, flagging address drift.
module rom_dump_sequencer
  import rom_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = PT5_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = PT5_ADDRESS_WIDTH,
  parameter int unsigned WORD_COUNT    = 512,
  parameter int unsigned RESET_CYCLES  = DEFAULT_RESET_CYCLES,
  parameter int unsigned PULSE_CYCLES  = DEFAULT_PULSE_CYCLES,
  parameter int unsigned GAP_CYCLES    = DEFAULT_GAP_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     rd_reset_n,
  output logic                     rd_increment,
  output logic                     rd_decrement,
  input  logic [ADDRESS_WIDTH-1:0] rd_address,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic [ADDRESS_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     addr_error
);

  // One extra bit so WORD_COUNT == 2**ADDRESS_WIDTH compares cleanly.
  localparam int unsigned IDX_W = ADDRESS_WIDTH + 1;
  localparam int unsigned TMR_W = TIMER_WIDTH;
  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(WORD_COUNT - 1);

  seq_state_e               state_q, state_d;
  logic [IDX_W-1:0]         index_q, index_d;
  logic [ADDRESS_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     rd_reset_n_q, rd_reset_n_d;
  logic                     rd_increment_q, rd_increment_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     addr_error_q, addr_error_d;

  logic                     tmr_load;
  logic [TMR_W-1:0]         tmr_value;
  logic                     tmr_expired_c;

  rom_seq_timer #(.WIDTH(TMR_W)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expired_c  (tmr_expired_c)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    addr_error_d = addr_error_q;
    tmr_load     = 1'b0;
    tmr_value    = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_d      = RD_RESET;
          index_d      = '0;
          addr_error_d = 1'b0;
          tmr_load     = 1'b1;
          tmr_value    = TMR_W'(RESET_CYCLES - 1);
        end
      end
      RD_RESET: begin
        if (tmr_expired_c) begin
          state_d   = SETTLE;
          tmr_load  = 1'b1;
          tmr_value = TMR_W'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (tmr_expired_c) begin
          if (IDX_W'(rd_address) != index_q) begin
            addr_error_d = 1'b1;
            state_d      = DONE;
          end else begin
            out_data_d = rd_data;
            out_addr_d = index_q[ADDRESS_WIDTH-1:0];
            state_d    = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (index_q == LAST_INDEX) begin
            state_d = DONE;
          end else begin
            index_d   = index_q + IDX_W'(1);
            state_d   = PULSE_HI;
            tmr_load  = 1'b1;
            tmr_value = TMR_W'(PULSE_CYCLES - 1);
          end
        end
      end
      PULSE_HI: begin
        if (tmr_expired_c) begin
          state_d   = PULSE_LO;
          tmr_load  = 1'b1;
          tmr_value = TMR_W'(GAP_CYCLES - 1);
        end
      end
      PULSE_LO: begin
        if (tmr_expired_c) begin
          state_d   = SETTLE;
          tmr_load  = 1'b1;
          tmr_value = TMR_W'(SETTLE_CYCLES - 1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort discards whatever this cycle would have captured.
    if (abort && is_busy(state_q)) begin
      state_d      = IDLE;
      index_d      = index_q;
      out_addr_d   = out_addr_q;
      out_data_d   = out_data_q;
      addr_error_d = addr_error_q;
      tmr_load     = 1'b1;
      tmr_value    = '0;
    end

    out_valid_d    = (state_d == PRESENT);
    rd_reset_n_d   = (state_d != RD_RESET);
    rd_increment_d = (state_d == PULSE_HI);
    busy_d         = is_busy(state_d);
    done_d         = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      index_q        <= '0;
      out_addr_q     <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      rd_reset_n_q   <= 1'b1;
      rd_increment_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      addr_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      out_addr_q     <= out_addr_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      rd_reset_n_q   <= rd_reset_n_d;
      rd_increment_q <= rd_increment_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      addr_error_q   <= addr_error_d;
    end
  end

  assign rd_reset_n   = rd_reset_n_q;
  assign rd_increment = rd_increment_q;
  assign rd_decrement = 1'b0;
  assign out_addr     = out_addr_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign addr_error   = addr_error_q;

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Directed self-checking bench for rom_dump_sequencer with a simple reader model.
module tb_rom_dump_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, abort, out_ready;
  logic          rd_reset_n, rd_increment, rd_decrement;
  logic [AW-1:0] rd_address;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_valid, busy, done, addr_error;

  logic          start2, out_ready2;
  logic          rd_reset_n2, rd_increment2, rd_decrement2;
  logic [AW-1:0] rd_address2;
  logic [DW-1:0] rd_data2;
  logic [AW-1:0] out_addr2;
  logic [DW-1:0] out_data2;
  logic          out_valid2, busy2, done2, addr_error2;

  rom_dump_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .rd_reset_n(rd_reset_n), .rd_increment(rd_increment), .rd_decrement(rd_decrement),
    .rd_address(rd_address), .rd_data(rd_data),
    .out_addr(out_addr), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .addr_error(addr_error)
  );

  rom_dump_sequencer #(.WORD_COUNT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start2), .abort(1'b0),
    .rd_reset_n(rd_reset_n2), .rd_increment(rd_increment2), .rd_decrement(rd_decrement2),
    .rd_address(rd_address2), .rd_data(rd_data2),
    .out_addr(out_addr2), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .busy(busy2), .done(done2), .addr_error(addr_error2)
  );

  assign rd_address2 = '0;
  assign rd_data2    = 8'hA5;

  // Reader model: address commits 2 cycles after an increment rising edge,
  // data register lags address by one cycle.
  logic       skip5;
  logic [8:0] mdl_addr;
  logic [7:0] mdl_data;
  logic       inc_seen, inc_pend;

  always @(posedge clk) begin
    inc_seen <= rd_increment;
    if (!rd_reset_n) begin
      mdl_addr <= 9'd0;
      inc_pend <= 1'b0;
    end else begin
      inc_pend <= rd_increment && !inc_seen;
      if (inc_pend) mdl_addr <= (skip5 && mdl_addr == 9'd4) ? 9'd6 : mdl_addr + 9'd1;
    end
    mdl_data <= mdl_addr[7:0] ^ 8'hA5;
  end

  assign rd_address = mdl_addr;
  assign rd_data    = mdl_data;

  // Transfer scoreboard, sampled mid-cycle.
  logic       clr_mon;
  int         xfer_cnt, seq_err, inc_cnt, rst_low_cnt, cyc, last_xfer, last_gap;
  logic [8:0] exp_addr;
  logic       inc_prev, saw6;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (clr_mon) begin
      xfer_cnt = 0; seq_err = 0; inc_cnt = 0; rst_low_cnt = 0;
      exp_addr = 9'd0; inc_prev = 1'b0; saw6 = 1'b0; last_gap = 0; last_xfer = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (out_addr !== exp_addr || out_data !== (exp_addr[7:0] ^ 8'hA5)) seq_err = seq_err + 1;
        if (out_addr == 9'd6) saw6 = 1'b1;
        if (xfer_cnt > 0) last_gap = cyc - last_xfer;
        last_xfer = cyc;
        exp_addr  = exp_addr + 9'd1;
        xfer_cnt  = xfer_cnt + 1;
      end
      if (rd_increment && !inc_prev) inc_cnt = inc_cnt + 1;
      inc_prev = rd_increment;
      if (!rd_reset_n) rst_low_cnt = rst_low_cnt + 1;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    tick(); clr_mon = 1'b1;
    tick(); clr_mon = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int   k;
    int   x2, inc2;
    logic [AW-1:0] a2;
    logic stall_ok;

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start2 = 1'b0; out_ready2 = 1'b1; skip5 = 1'b0; clr_mon = 1'b0;
    cyc = 0;
    #12;
    check("rst_busy",       32'(busy),         32'd0);
    check("rst_done",       32'(done),         32'd0);
    check("rst_valid",      32'(out_valid),    32'd0);
    check("rst_rd_reset_n", 32'(rd_reset_n),   32'd1);
    check("rst_rd_inc",     32'(rd_increment), 32'd0);
    check("rst_rd_dec",     32'(rd_decrement), 32'd0);
    check("rst_addr_err",   32'(addr_error),   32'd0);
    check("rst_out_addr",   32'(out_addr),     32'd0);
    check("rst_out_data",   32'(out_data),     32'd0);
    tick(); reset_n = 1'b1;
    tick();

    // Full run with out_ready tied high.
    clear_mon();
    pulse_start();
    check("run_busy", 32'(busy), 32'd1);
    wait_done(6000, "run_done");
    tick();
    check("run_xfers",    32'(xfer_cnt),    32'd512);
    check("run_seq",      32'(seq_err),     32'd0);
    check("run_incs",     32'(inc_cnt),     32'd511);
    check("run_rst_low",  32'(rst_low_cnt), 32'd2);
    check("run_gap",      32'(last_gap),    32'd10);
    check("run_addr_err", 32'(addr_error),  32'd0);
    check("run_busy_end", 32'(busy),        32'd0);

    // Backpressure for 7 cycles on word 3.
    clear_mon();
    pulse_start();
    k = 0;
    while (!(out_valid && out_addr == 9'd3) && k < 100) begin tick(); k++; end
    check("bp_reach3", 32'(out_valid && out_addr == 9'd3), 32'd1);
    out_ready = 1'b0;
    stall_ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (!(out_valid && out_addr == 9'd3 && out_data == 8'hA6 && !rd_increment)) stall_ok = 1'b0;
    end
    check("bp_hold", 32'(stall_ok), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_released", 32'(out_valid), 32'd0);
    k = 0;
    while (!(out_valid && out_addr == 9'd4) && k < 30) begin tick(); k++; end
    check("bp_word4", 32'(out_valid && out_addr == 9'd4 && out_data == 8'hA1), 32'd1);
    wait_done(6000, "bp_done");
    tick();
    check("bp_xfers", 32'(xfer_cnt), 32'd512);
    check("bp_seq",   32'(seq_err),  32'd0);
    check("bp_incs",  32'(inc_cnt),  32'd511);

    // Reader skips address 5.
    skip5 = 1'b1;
    clear_mon();
    pulse_start();
    wait_done(300, "fault_done");
    tick();
    check("fault_addr_err", 32'(addr_error), 32'd1);
    check("fault_no6",      32'(saw6),       32'd0);
    check("fault_xfers",    32'(xfer_cnt),   32'd5);
    check("fault_valid",    32'(out_valid),  32'd0);
    skip5 = 1'b0;

    // Abort during the increment pulse following word 10.
    clear_mon();
    pulse_start();
    k = 0;
    while (!(rd_increment && out_addr == 9'd10) && k < 300) begin tick(); k++; end
    check("abort_reach", 32'(rd_increment && out_addr == 9'd10), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy",     32'(busy),         32'd0);
    check("abort_inc",      32'(rd_increment), 32'd0);
    check("abort_valid",    32'(out_valid),    32'd0);
    check("abort_done",     32'(done),         32'd0);
    check("abort_rd_rst_n", 32'(rd_reset_n),   32'd1);
    check("abort_addr_err", 32'(addr_error),   32'd0);
    tick(); tick();
    check("abort_idle", 32'(busy), 32'd0);
    clear_mon();
    pulse_start();
    wait_done(6000, "restart_done");
    tick();
    check("restart_rst_low", 32'(rst_low_cnt), 32'd2);
    check("restart_xfers",   32'(xfer_cnt),    32'd512);
    check("restart_seq",     32'(seq_err),     32'd0);

    // Single-word configuration.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    x2 = 0; inc2 = 0; a2 = '1;
    for (int i = 0; i < 60; i++) begin
      if (out_valid2) begin x2++; a2 = out_addr2; end
      if (rd_increment2) inc2++;
      if (done2) break;
      tick();
    end
    check("wc1_xfers", 32'(x2),        32'd1);
    check("wc1_addr",  32'(a2),        32'd0);
    check("wc1_data",  32'(out_data2), 32'hA5);
    check("wc1_incs",  32'(inc2),      32'd0);
    check("wc1_done",  32'(done2),     32'd1);

    // Async reset mid-SETTLE, with a start that must be ignored first.
    pulse_start();
    k = 0;
    while (rd_reset_n && k < 10) begin tick(); k++; end
    k = 0;
    while (!rd_reset_n && k < 10) begin tick(); k++; end
    check("mid_in_settle", 32'(busy && rd_reset_n && !out_valid), 32'd1);
    pulse_start();
    check("busy_start_ign_rst", 32'(rd_reset_n), 32'd1);
    check("busy_start_ign_bsy", 32'(busy),       32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("areset_busy",     32'(busy),         32'd0);
    check("areset_rd_rst_n", 32'(rd_reset_n),   32'd1);
    check("areset_valid",    32'(out_valid),    32'd0);
    check("areset_out_addr", 32'(out_addr),     32'd0);
    check("areset_out_data", 32'(out_data),     32'd0);
    check("areset_done2",    32'(done2),        32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
